// File: rtl/serial_compare.sv
// Bit-serial unsigned magnitude comparator, operands arrive MSB first.
// The first differing bit pair decides the result; later pairs are consumed only to finish the count.
module serial_compare #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic a_bit,
    input  logic b_bit,
    input  logic bit_valid,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dec_q, dec_d;
    logic igt_q, igt_d;
    logic ilt_q, ilt_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic eq_q, eq_d;
    logic gt_q, gt_d;
    logic lt_q, lt_d;
    logic accept;

    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        igt_d   = igt_q;
        ilt_d   = ilt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    dec_d   = 1'b0;
                    igt_d   = 1'b0;
                    ilt_d   = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Bit values are only looked at when qualified, so X on a stall is harmless
                if (bit_valid) begin
                    if (!dec_q && (a_bit != b_bit)) begin
                        dec_d = 1'b1;
                        igt_d = a_bit;
                        ilt_d = b_bit;
                    end
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        eq_d    = !dec_d;
                        gt_d    = igt_d;
                        lt_d    = ilt_d;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            igt_q   <= 1'b0;
            ilt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            igt_q   <= igt_d;
            ilt_q   <= ilt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_compare.sv
// Directed bench for serial_compare: integer-level reference model checked every cycle,
// plus hand-computed result and latency expectations per vector.
module tb_serial_compare;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic bit_valid = 1'b0;
    logic busy, done, eq, gt, lt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    serial_compare #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a_bit(a_bit),
        .b_bit(b_bit),
        .bit_valid(bit_valid),
        .busy(busy),
        .done(done),
        .eq(eq),
        .gt(gt),
        .lt(lt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: accumulate operands as integers, compare arithmetically at the end
    typedef enum {M_IDLE, M_RUN, M_END} mph_t;
    mph_t ph;
    int m_n;
    logic [15:0] m_a, m_b;
    logic m_eq, m_gt, m_lt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph   <= M_IDLE;
            m_n  <= 0;
            m_a  <= '0;
            m_b  <= '0;
            m_eq <= 1'b0;
            m_gt <= 1'b0;
            m_lt <= 1'b0;
        end else if (ph != M_RUN) begin
            if (start) begin
                ph   <= M_RUN;
                m_n  <= 0;
                m_a  <= '0;
                m_b  <= '0;
                m_eq <= 1'b0;
                m_gt <= 1'b0;
                m_lt <= 1'b0;
            end else begin
                ph <= M_IDLE;
            end
        end else if (bit_valid) begin
            m_a <= {m_a[14:0], a_bit};
            m_b <= {m_b[14:0], b_bit};
            m_n <= m_n + 1;
            if (m_n == W - 1) begin
                ph   <= M_END;
                m_eq <= ({m_a[14:0], a_bit} == {m_b[14:0], b_bit});
                m_gt <= ({m_a[14:0], a_bit} >  {m_b[14:0], b_bit});
                m_lt <= ({m_a[14:0], a_bit} <  {m_b[14:0], b_bit});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_busy", busy, ph == M_RUN);
        chk("model_done", done, ph == M_END);
        chk("model_eq", eq, m_eq);
        chk("model_gt", gt, m_gt);
        chk("model_lt", lt, m_lt);
    end

    // res = {eq,gt,lt}; lat = spec cycle offset of done from the accepting edge
    task automatic run(input string nm, input logic [3:0] a, input logic [3:0] b,
                       input int stall_at, input int stall_len, input bit mid_start,
                       input bit pre_started, input bit chain,
                       input logic [2:0] res, input int lat);
        int t0;
        bit seen;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
            a_bit = 1'bx;
            b_bit = 1'bx;
            bit_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        chk({nm, "_accept_clr"}, {eq, gt, lt}, 3'b000);
        for (int i = 0; i < W; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    start = 1'b0;
                    bit_valid = 1'b0;
                    a_bit = 1'bx;
                    b_bit = 1'bx;
                end
            end
            @(negedge clk);
            start = mid_start && (i == 1);
            bit_valid = 1'b1;
            a_bit = a[W-1-i];
            b_bit = b[W-1-i];
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, seen, 1'b1);
        chk({nm, "_latency"}, cyc - t0 + 1, lat);
        chk({nm, "_result"}, {eq, gt, lt}, res);
        bit_valid = 1'b0;
        a_bit = 1'b0;
        b_bit = 1'b0;
        start = chain;
    endtask

    initial begin
        #2;
        chk("rst_outputs", {busy, done, eq, gt, lt}, 5'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run("eq1010", 4'b1010, 4'b1010, -1, 0, 1'b0, 1'b0, 1'b0, 3'b100, 5);
        run("gt_msb", 4'b1000, 4'b0111, -1, 0, 1'b0, 1'b0, 1'b0, 3'b010, 5);
        run("lt_stall", 4'b0101, 4'b0110, 2, 2, 1'b0, 1'b0, 1'b0, 3'b001, 7);
        run("lt_midstart", 4'b0110, 4'b1001, -1, 0, 1'b1, 1'b0, 1'b1, 3'b001, 5);
        run("eq1111_chain", 4'b1111, 4'b1111, -1, 0, 1'b0, 1'b1, 1'b0, 3'b100, 5);
        run("lt_lsb", 4'b1110, 4'b1111, 0, 1, 1'b0, 1'b0, 1'b0, 3'b001, 6);

        // Abort after two consumed bits
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bit_valid = 1'b1;
        a_bit = 1'b1;
        b_bit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, eq, gt, lt}, 5'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_hold", {busy, done, eq, gt, lt}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        bit_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {busy, done}, 2'b00);
        end

        run("gt_after_rst", 4'b0011, 4'b0010, -1, 0, 1'b0, 1'b0, 1'b0, 3'b010, 5);
        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_compare.md
SERIAL_COMPARE -- requirements
Module: serial_compare

Interface
REQ-001 WIDTH, default 4: operand width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request for a new comparison.
REQ-005 a_bit  input  1  serial operand A bit, MSB first.
REQ-006 b_bit  input  1  serial operand B bit, MSB first.
REQ-007 bit_valid  input  1  qualifies a_bit/b_bit for the current cycle.
REQ-008 busy  output  1  high while in SHIFT.
REQ-009 done  output  1  one-cycle pulse marking the result update.
REQ-010 eq  output  1  A equal to B (unsigned).
REQ-011 gt  output  1  A greater than B (unsigned).
REQ-012 lt  output  1  A less than B (unsigned).

Function
REQ-013 FSM states: IDLE, SHIFT, DONE; encoding free.
REQ-014 IDLE: start=1 -> SHIFT next edge; bit counter cleared to 0; internal decided/gt/lt flags cleared; eq/gt/lt outputs cleared to 0 on that same edge.
REQ-015 Bits are sampled only in SHIFT; a_bit/b_bit/bit_valid in the start cycle are ignored.
REQ-016 SHIFT, bit_valid=1: one bit pair consumed; counter increments by 1.
REQ-017 SHIFT, bit_valid=0: stall; counter, flags and state unchanged; a_bit/b_bit values (including X) have no effect.
REQ-018 Decision: first consumed pair with a_bit != b_bit sets decided; a=1,b=0 sets internal gt; a=0,b=1 sets internal lt; pairs after decided are consumed but do not change the flags.
REQ-019 Consuming the WIDTH-th pair (counter = WIDTH-1) -> DONE next edge.
REQ-020 Entering DONE: eq = not decided, gt = internal gt, lt = internal lt, all registered; done=1 for exactly the DONE cycle.
REQ-021 DONE always leaves after one cycle: start=1 -> SHIFT, with REQ-014 clearing applied; start=0 -> IDLE.
REQ-022 start while in SHIFT is ignored; no restart, no effect on counter or flags.
REQ-023 eq/gt/lt hold their values from DONE until the edge that accepts the next start.
REQ-024 After any completed comparison, exactly one of eq/gt/lt is 1; between start acceptance and DONE, all three are 0.
REQ-025 Latency: start accepted at edge T with bit_valid high continuously from T+1 -> done high in cycle T+WIDTH+1; each bit_valid=0 cycle in SHIFT adds one cycle.
REQ-026 Counter width is ceil(log2(WIDTH)) bits; the counter never wraps, because the WIDTH-th pair forces DONE.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, counter=0, internal flags=0, busy=0, done=0, eq=0, gt=0, lt=0.
REQ-028 Reset during SHIFT or DONE aborts the comparison: no done pulse and no partial result; the first start after rst_n rises runs a normal comparison.
REQ-029 Outputs stay at the reset values while rst_n=0, regardless of start or bit_valid.

Verification (WIDTH=4; start accepted at edge T)
REQ-030 A=1010, B=1010, bit_valid high T+1..T+4 -> done=1 in cycle T+5; eq=1, gt=0, lt=0.
REQ-031 A=1000, B=0111 -> gt=1, eq=0, lt=0; MSB decides, and later bits B=1 vs A=0 are ignored.
REQ-032 A=0101, B=0110, bit_valid low for 2 cycles after the second bit -> lt=1; done in cycle T+7.
REQ-033 start pulsed mid-SHIFT -> ignored, and the result matches the original operands; start held in the DONE cycle -> second comparison (A=1111, B=1111) gives done 5 cycles later with eq=1, and eq/gt/lt read 0 in between.
REQ-034 rst_n pulsed low after 2 consumed bits -> all outputs 0 immediately, state IDLE, no done; a following compare of A=0011, B=0010 -> gt=1.
